// File: rtl/warp_dmem_responder_pkg.sv
// Shared types and helpers for the warp data-memory responder.
//   mem_size_t         : access size of a dmem request (byte / half / word)
//   dmem_resp_state_t  : responder FSM states
//   mem_byte_en        : byte enables for a store of a given size at a byte offset
//   mem_load_extract   : selects and zero-extends the addressed byte/half/word
//   mem_store_data     : replicates store data LSBs into every candidate byte lane
package warp_dmem_responder_pkg;

   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DRAIN,
      RESP
   } dmem_resp_state_t;

   // Offsets are forced aligned: HALF only looks at off[1], WORD ignores off.
   function automatic logic [3:0] mem_byte_en(mem_size_t size, logic [1:0] off);
      case (size)
         MEM_BYTE: return 4'b0001 << off;
         MEM_HALF: return off[1] ? 4'b1100 : 4'b0011;
         default:  return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] mem_load_extract(mem_size_t size, logic [1:0] off,
                                                    logic [31:0] word);
      case (size)
         MEM_BYTE: return {24'b0, word[{off, 3'b000} +: 8]};
         MEM_HALF: return {16'b0, (off[1] ? word[31:16] : word[15:0])};
         default:  return word;
      endcase
   endfunction

   // Data is placed in every lane it could land in; the byte enables pick one.
   function automatic logic [31:0] mem_store_data(mem_size_t size, logic [31:0] wdata);
      case (size)
         MEM_BYTE: return {4{wdata[7:0]}};
         MEM_HALF: return {2{wdata[15:0]}};
         default:  return wdata;
      endcase
   endfunction

endpackage

// File: rtl/warp_dmem_responder_sram.sv
// Single-port, byte-enabled, synchronous-read word SRAM (2**AW x 32b).
//   clk   : clock
//   en    : access strobe (read when we=0, write when we=1)
//   we    : write enable
//   be    : per-byte write enables
//   addr  : word address
//   wdata : write data
//   rdata : read data, valid the cycle after a read access; holds otherwise
// Contents are not reset.
module dmem_sram_1rw #(
   parameter int AW = 14
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [2**AW];
   logic [31:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
         end else begin
            rdata_q <= mem[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/warp_dmem_responder.sv
// Memory-side responder for the SIMT per-lane data memory interface.
// Takes one warp-wide load or store, walks the active lanes lowest-first onto a
// single-port SRAM (one lane per cycle) and returns one warp-wide response.
//   clk, rst_n            : clock, async active-low reset
//   dmem_req              : request valid (accepted when dmem_ready)
//   dmem_lane_valid       : active lane mask
//   dmem_addr / wdata     : per-lane byte address / store data (flattened)
//   dmem_we, dmem_size    : store/load, access size
//   dmem_ready            : high only while idle
//   dmem_resp_valid       : one-cycle response strobe
//   dmem_rdata            : per-lane zero-extended load data (0 for stores / idle lanes)
//   dmem_lane_resp_valid  : accepted lane mask
module warp_dmem_responder
   import warp_dmem_responder_pkg::*;
#(
   parameter int WARP_SIZE  = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_BYTES  = 65536
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             dmem_req,
   input  logic [WARP_SIZE-1:0]             dmem_lane_valid,
   input  logic [WARP_SIZE*ADDR_WIDTH-1:0]  dmem_addr,
   input  logic [WARP_SIZE*DATA_WIDTH-1:0]  dmem_wdata,
   input  logic                             dmem_we,
   input  mem_size_t                        dmem_size,
   output logic                             dmem_ready,
   output logic                             dmem_resp_valid,
   output logic [WARP_SIZE*DATA_WIDTH-1:0]  dmem_rdata,
   output logic [WARP_SIZE-1:0]             dmem_lane_resp_valid
);

   localparam int LANE_W = $clog2(WARP_SIZE);
   localparam int MEM_AW = $clog2(MEM_BYTES) - 2;

   dmem_resp_state_t state_q, state_d;
   logic [WARP_SIZE-1:0]                  mask_q, mask_d, pend_q, pend_d;
   logic [WARP_SIZE-1:0][ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [WARP_SIZE-1:0][DATA_WIDTH-1:0]  wdata_q, wdata_d, rdata_q, rdata_d;
   logic                                  we_q, we_d;
   mem_size_t                             size_q, size_d;
   // Lane issued last cycle and whether its read data lands this cycle.
   logic [LANE_W-1:0]                     lane_q, lane_d;
   logic                                  cap_q, cap_d;

   logic [LANE_W-1:0]     sel;
   logic                  issue;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [31:0]           sram_rdata;
   logic                  unused_addr_bits;

   // Lowest-index pending lane wins.
   always_comb begin
      sel = '0;
      for (int i = WARP_SIZE - 1; i >= 0; i--) begin
         if (pend_q[i]) sel = LANE_W'(i);
      end
   end

   assign issue    = (state_q == ACCESS);
   assign sel_addr = addr_q[sel];

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      pend_d  = pend_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      we_d    = we_q;
      size_d  = size_q;
      lane_d  = lane_q;
      cap_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (dmem_req) begin
               mask_d  = dmem_lane_valid;
               pend_d  = dmem_lane_valid;
               addr_d  = dmem_addr;
               wdata_d = dmem_wdata;
               we_d    = dmem_we;
               size_d  = dmem_size;
               rdata_d = '0;
               state_d = (|dmem_lane_valid) ? ACCESS : RESP;
            end
         end
         ACCESS: begin
            pend_d[sel] = 1'b0;
            lane_d      = sel;
            cap_d       = !we_q;
            if (pend_d == '0) state_d = DRAIN;
         end
         DRAIN:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Capture can only be pending in ACCESS/DRAIN, never alongside an accept.
      if (cap_q) begin
         rdata_d[lane_q] = DATA_WIDTH'(mem_load_extract(size_q, addr_q[lane_q][1:0], sram_rdata));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mask_q  <= '0;
         pend_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         we_q    <= 1'b0;
         size_q  <= MEM_WORD;
         lane_q  <= '0;
         cap_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         pend_q  <= pend_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         we_q    <= we_d;
         size_q  <= size_d;
         lane_q  <= lane_d;
         cap_q   <= cap_d;
      end
   end

   dmem_sram_1rw #(.AW(MEM_AW)) u_sram (
      .clk   (clk),
      .en    (issue),
      .we    (we_q),
      .be    (mem_byte_en(size_q, sel_addr[1:0])),
      .addr  (sel_addr[MEM_AW+1:2]),
      .wdata (mem_store_data(size_q, wdata_q[sel][31:0])),
      .rdata (sram_rdata)
   );

   // Address bits above the SRAM size wrap away.
   assign unused_addr_bits = ^addr_q;

   assign dmem_ready           = (state_q == IDLE);
   assign dmem_resp_valid      = (state_q == RESP);
   assign dmem_rdata           = rdata_q;
   assign dmem_lane_resp_valid = mask_q;

endmodule

// File: tb/tb_warp_dmem_responder.sv
module tb_warp_dmem_responder;
   import warp_dmem_responder_pkg::*;

   localparam int W  = 32;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MB = 65536;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic                dmem_req = 1'b0;
   logic [W-1:0]        dmem_lane_valid = '0;
   logic [W*AW-1:0]     dmem_addr = '0;
   logic [W*DW-1:0]     dmem_wdata = '0;
   logic                dmem_we = 1'b0;
   mem_size_t           dmem_size = MEM_WORD;
   logic                dmem_ready;
   logic                dmem_resp_valid;
   logic [W*DW-1:0]     dmem_rdata;
   logic [W-1:0]        dmem_lane_resp_valid;

   warp_dmem_responder #(.WARP_SIZE(W), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_BYTES(MB)) dut (
      .clk(clk), .rst_n(rst_n), .dmem_req(dmem_req), .dmem_lane_valid(dmem_lane_valid),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_size(dmem_size),
      .dmem_ready(dmem_ready), .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata),
      .dmem_lane_resp_valid(dmem_lane_resp_valid));

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct { int b; int n; logic [31:0] d; } op_t;
   logic [7:0]            mmem [MB];
   bit                    m_busy = 1'b0;
   int                    m_t = 0, m_lat = 0;
   bit                    m_we = 1'b0;
   op_t                   ops[$];
   logic [W-1:0]          m_mask = '0;
   logic [W-1:0][DW-1:0]  m_rd = '0;

   function automatic int nbytes(mem_size_t s);
      case (s)
         MEM_BYTE: return 1;
         MEM_HALF: return 2;
         default:  return 4;
      endcase
   endfunction

   function automatic int base_of(logic [31:0] a, int n);
      return int'(a & 32'(MB - 1)) & ~(n - 1);
   endfunction

   task automatic model_accept();
      int n, cnt;
      logic [31:0] v;
      n = nbytes(dmem_size);
      cnt = 0;
      m_busy = 1'b1; m_t = 1; m_we = dmem_we; m_mask = dmem_lane_valid; m_rd = '0;
      ops.delete();
      for (int i = 0; i < W; i++) begin
         if (dmem_lane_valid[i]) begin
            int b;
            cnt++;
            b = base_of(dmem_addr[i*AW +: AW], n);
            if (dmem_we) begin
               ops.push_back('{b: b, n: n, d: dmem_wdata[i*DW +: DW]});
            end else begin
               v = '0;
               for (int j = 0; j < n; j++) v[8*j +: 8] = mmem[b + j];
               m_rd[i] = v;
            end
         end
      end
      m_lat = (cnt == 0) ? 1 : cnt + 2;
   endtask

   initial begin
      for (int i = 0; i < MB; i++) mmem[i] = 8'h00;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_busy = 1'b0; m_mask = '0; m_rd = '0;
         end else if (!m_busy) begin
            if (dmem_req) model_accept();
         end else begin
            // The k-th active lane reaches memory on the edge closing cycle k+1.
            if (m_we && (m_t - 1) < ops.size()) begin
               op_t o;
               o = ops[m_t - 1];
               for (int j = 0; j < o.n; j++) mmem[o.b + j] = o.d[8*j +: 8];
            end
            if (m_t == m_lat) m_busy = 1'b0;
            else m_t++;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            chk("rst_ready", {31'b0, dmem_ready}, 32'd1);
            chk("rst_resp_valid", {31'b0, dmem_resp_valid}, 32'd0);
            chk("rst_lane_resp_valid", dmem_lane_resp_valid, 32'd0);
            chk("rst_rdata_any", {31'b0, |dmem_rdata}, 32'd0);
         end else begin
            bit er;
            er = m_busy && (m_t == m_lat);
            chk("ready", {31'b0, dmem_ready}, {31'b0, !m_busy});
            chk("resp_valid", {31'b0, dmem_resp_valid}, {31'b0, er});
            if (er) begin
               chk("lane_resp_valid", dmem_lane_resp_valid, m_mask);
               for (int i = 0; i < W; i++)
                  chk($sformatf("rdata[%0d]", i), dmem_rdata[i*DW +: DW], m_rd[i]);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic go();
      int k;
      k = 0;
      @(negedge clk);
      while (!dmem_ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (!dmem_ready) chk("ready_timeout", {31'b0, dmem_ready}, 32'd1);
      dmem_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      dmem_req = 1'b0;
   endtask

   task automatic wait_resp(output int lat, output logic [W*DW-1:0] rd,
                            output logic [W-1:0] lv, input bit garb);
      lat = 1;
      while (!dmem_resp_valid && lat < 200) begin
         if (garb) begin
            dmem_req        = 1'($urandom_range(0, 1));
            dmem_lane_valid = $urandom;
            dmem_we         = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         lat++;
      end
      if (!dmem_resp_valid) chk("resp_timeout", {31'b0, dmem_resp_valid}, 32'd1);
      rd = dmem_rdata;
      lv = dmem_lane_resp_valid;
      dmem_req = 1'b0;
   endtask

   task automatic set_lanes(input logic [31:0] base, input logic [31:0] stride,
                            input logic [31:0] dbase, input logic [31:0] dstride);
      for (int i = 0; i < W; i++) begin
         dmem_addr[i*AW +: AW]  = base + stride * 32'(i);
         dmem_wdata[i*DW +: DW] = dbase + dstride * 32'(i);
      end
   endtask

   task automatic req(input logic [W-1:0] mask, input bit we, input mem_size_t sz,
                      output int lat, output logic [W*DW-1:0] rd, output logic [W-1:0] lv);
      dmem_lane_valid = mask;
      dmem_we = we;
      dmem_size = sz;
      go();
      wait_resp(lat, rd, lv, 1'b0);
   endtask

   int              lat;
   logic [W*DW-1:0] rd;
   logic [W-1:0]    lv;

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("t1_ready", {31'b0, dmem_ready}, 32'd1);
      chk("t1_resp_valid", {31'b0, dmem_resp_valid}, 32'd0);
      chk("t1_lane_resp_valid", dmem_lane_resp_valid, 32'd0);
      chk("t1_rdata_any", {31'b0, |dmem_rdata}, 32'd0);
      rst_n = 1'b1;

      // Known contents for the low 1 KiB used by the loads below.
      for (int k = 0; k < 8; k++) begin
         set_lanes(32'(k * 128), 4, 0, 0);
         req('1, 1'b1, MEM_WORD, lat, rd, lv);
      end

      // Full-warp word store then load.
      set_lanes(32'h1000, 4, 0, 1);
      req('1, 1'b1, MEM_WORD, lat, rd, lv);
      chk("t2_store_lat", lat, 32'd34);
      chk("t2_store_rdata_any", {31'b0, |rd}, 32'd0);
      req('1, 1'b0, MEM_WORD, lat, rd, lv);
      chk("t2_load_lat", lat, 32'd34);
      chk("t2_load_lanes", lv, 32'hFFFF_FFFF);
      for (int i = 0; i < W; i++) chk($sformatf("t2_rdata[%0d]", i), rd[i*DW +: DW], 32'(i));

      // Byte store and sized loads.
      dmem_addr[0 +: AW] = 32'h101; dmem_wdata[0 +: DW] = 32'h1234_56AB;
      req(32'h1, 1'b1, MEM_BYTE, lat, rd, lv);
      chk("t3_store_lat", lat, 32'd3);
      dmem_addr[0 +: AW] = 32'h100;
      req(32'h1, 1'b0, MEM_WORD, lat, rd, lv);
      chk("t3_word", rd[0 +: DW], 32'h0000_AB00);
      dmem_addr[0 +: AW] = 32'h101;
      req(32'h1, 1'b0, MEM_BYTE, lat, rd, lv);
      chk("t3_byte", rd[0 +: DW], 32'h0000_00AB);
      dmem_addr[0 +: AW] = 32'h103;
      req(32'h1, 1'b0, MEM_HALF, lat, rd, lv);
      chk("t3_half", rd[0 +: DW], 32'h0000_0000);

      // Sparse load.
      set_lanes(32'h1000, 4, 0, 0);
      req(32'h8000_0001, 1'b0, MEM_WORD, lat, rd, lv);
      chk("t4_lat", lat, 32'd4);
      chk("t4_lanes", lv, 32'h8000_0001);
      chk("t4_lane31", rd[31*DW +: DW], 32'd31);
      chk("t4_lane5", rd[5*DW +: DW], 32'd0);

      // Same-address stores, highest lane wins; empty mask.
      set_lanes(32'h200, 0, 0, 1);
      req(32'h0000_0088, 1'b1, MEM_WORD, lat, rd, lv);
      chk("t5_store_lat", lat, 32'd4);
      req(32'h1, 1'b0, MEM_WORD, lat, rd, lv);
      chk("t5_load", rd[0 +: DW], 32'd7);
      req(32'h0, 1'b0, MEM_WORD, lat, rd, lv);
      chk("t5_empty_lat", lat, 32'd1);
      chk("t5_empty_lanes", lv, 32'd0);

      // Reset after five lanes of a full-warp store have been issued.
      set_lanes(32'h1000, 4, 100, 1);
      dmem_lane_valid = '1; dmem_we = 1'b1; dmem_size = MEM_WORD;
      go();
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_ready", {31'b0, dmem_ready}, 32'd1);
      chk("t6_no_resp", {31'b0, dmem_resp_valid}, 32'd0);
      req('1, 1'b0, MEM_WORD, lat, rd, lv);
      for (int i = 0; i < W; i++)
         chk($sformatf("t6_rdata[%0d]", i), rd[i*DW +: DW], (i < 5) ? 32'(100 + i) : 32'(i));

      // Randomised traffic, with stray requests while busy.
      for (int r = 0; r < 40; r++) begin
         logic [W-1:0] m;
         bit narrow;
         case ($urandom_range(0, 3))
            0:       m = $urandom;
            1:       m = $urandom & $urandom & $urandom & $urandom;
            2:       m = '1;
            default: m = W'(1) << $urandom_range(0, W - 1);
         endcase
         narrow = 1'($urandom_range(0, 1));
         for (int i = 0; i < W; i++) begin
            dmem_addr[i*AW +: AW]  = ($urandom & 32'hFFFF_0000) |
                                     (narrow ? $urandom_range(0, 15) : $urandom_range(0, 1023));
            dmem_wdata[i*DW +: DW] = $urandom;
         end
         dmem_lane_valid = m;
         dmem_we = 1'($urandom_range(0, 1));
         dmem_size = mem_size_t'($urandom_range(0, 2));
         go();
         wait_resp(lat, rd, lv, 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
